argmax_classifier: RTL and testbench

- Final stage of the CNN digit classifier. Sits directly downstream of the last fc_layer instance.
- After fc_layer asserts done, the controller pulses start. The block then sequentially reads the NUM_CLASSES output scores from the FC output buffer and reports the index of the largest score as the predicted digit.
- Uses the same start/done handshake and the same synchronous-read memory port style as fc_layer.

---
 rtl/argmax_classifier.sv | 111 +++++++++++
 tb/tb_argmax_classifier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Scans NUM_CLASSES scores from a synchronous-read buffer and reports the index
// and value of the largest one; ties resolve to the lowest index.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int SIGNED_EN   = 1,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_val,
    output logic [1:0]        fsm_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy is
    // high from the accepting edge until done, and done is a one-cycle pulse
    // during which class_idx/max_val already carry the new result.
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

    state_t             state, next_state;
    logic               live;        // rd_data holds a requested score this cycle
    logic [IDX_W-1:0]   data_idx;    // class index of the score on rd_data
    logic               best_valid;
    logic [IDX_W-1:0]   best_idx;
    logic [DATA_W-1:0]  best_val;
    logic               greater;

    assign fsm_state = state;

    always_comb begin
        if (SIGNED_EN != 0)
            greater = $signed(rd_data) > $signed(best_val);
        else
            greater = rd_data > best_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: if (rd_addr == LAST_ADDR) next_state = DRAIN;
            DRAIN: next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_idx  <= '0;
            max_val    <= '0;
            live       <= 1'b0;
            data_idx   <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_val   <= '0;
        end else begin
            done <= 1'b0;
            if (live) begin
                if (!best_valid || greater) begin
                    best_val <= rd_data;
                    best_idx <= data_idx;
                end
                best_valid <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    live <= 1'b0;
                    if (start) begin
                        rd_addr    <= '0;
                        busy       <= 1'b1;
                        best_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    live     <= 1'b1;
                    data_idx <= IDX_W'(rd_addr);
                    if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 1'b1;
                end
                DRAIN: live <= 1'b0;
                // Results are published together with done, so a scan in
                // progress never disturbs the previously reported answer.
                DONE: begin
                    class_idx <= best_idx;
                    max_val   <= best_val;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: live <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: three instances (10 signed, 10 unsigned, 1 signed)
// each fed by a synchronous-read buffer model; table vectors, corner sequences, random.
module tb_argmax_classifier;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [2:0] busy_v, done_v;
    logic [9:0] raddr [3];
    logic [7:0] rdat [3];
    logic [3:0] cidx [3];
    logic [7:0] mval [3];
    logic [1:0] st [3];
    logic [7:0] mem [3][10];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    argmax_classifier #(.NUM_CLASSES(10), .SIGNED_EN(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .rd_addr(raddr[0]), .rd_data(rdat[0]),
        .busy(busy_v[0]), .done(done_v[0]), .class_idx(cidx[0]), .max_val(mval[0]), .fsm_state(st[0]));
    argmax_classifier #(.NUM_CLASSES(10), .SIGNED_EN(0)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .rd_addr(raddr[1]), .rd_data(rdat[1]),
        .busy(busy_v[1]), .done(done_v[1]), .class_idx(cidx[1]), .max_val(mval[1]), .fsm_state(st[1]));
    argmax_classifier #(.NUM_CLASSES(1), .SIGNED_EN(1)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .rd_addr(raddr[2]), .rd_data(rdat[2]),
        .busy(busy_v[2]), .done(done_v[2]), .class_idx(cidx[2]), .max_val(mval[2]), .fsm_state(st[2]));

    function automatic int depth(input int d);
        return (d == 2) ? 1 : 10;
    endfunction

    // Synchronous-read buffers: data for an address appears one cycle later.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++)
            rdat[d] <= (int'(raddr[d]) < depth(d)) ? mem[d][raddr[d][3:0]] : 8'h00;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int score(input int d, input logic [7:0] x);
        return (d == 1) ? int'(x) : int'($signed(x));
    endfunction

    // Reference: first maximum over the buffer contents, using integer values.
    task automatic ref_model(input int d, output logic [3:0] idx, output logic [7:0] val);
        int best;
        best = score(d, mem[d][0]);
        idx = 4'd0;
        for (int i = 1; i < depth(d); i++) begin
            if (score(d, mem[d][i]) > best) begin
                best = score(d, mem[d][i]);
                idx = 4'(i);
            end
        end
        val = mem[d][idx];
    endtask

    task automatic run_scan(input int d, input int pulse_at, output int lat,
                            output logic [3:0] idx, output logic [7:0] val, output logic ok_side);
        logic [3:0] p_idx;
        logic [7:0] p_val;
        int n;
        n = depth(d);
        p_idx = cidx[d];
        p_val = mval[d];
        ok_side = 1'b1;
        lat = 0;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        if (!busy_v[d] || raddr[d] != 10'd0) ok_side = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (pulse_at >= 0) start_v[d] = (lat == pulse_at);
            if (done_v[d]) break;
            if (!busy_v[d] || cidx[d] != p_idx || mval[d] != p_val) ok_side = 1'b0;
            if (int'(raddr[d]) != ((lat < n) ? lat : n - 1)) ok_side = 1'b0;
        end
        start_v[d] = 1'b0;
        idx = cidx[d];
        val = mval[d];
        if (busy_v[d]) ok_side = 1'b0;
        @(posedge clk);
        #1;
        if (done_v[d]) ok_side = 1'b0;
    endtask

    typedef struct {
        int         d;
        logic [7:0] data [10];
        logic [3:0] idx;
        logic [7:0] val;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int lat, t1, t2, cnt;
        logic [3:0] idx, e_idx;
        logic [7:0] val, e_val;
        logic ok;

        tbl[0].d = 0; tbl[0].data = '{8'h03, 8'hFB, 8'h11, 8'h00, 8'h2A, 8'h08, 8'hFF, 8'h2A, 8'h09, 8'h02};
        tbl[0].idx = 4'd4; tbl[0].val = 8'h2A;
        tbl[1].d = 0; tbl[1].data = '{8'h80, 8'hF9, 8'hFD, 8'h9C, 8'hFD, 8'hCE, 8'hF7, 8'hF7, 8'h80, 8'hEC};
        tbl[1].idx = 4'd2; tbl[1].val = 8'hFD;
        tbl[2].d = 1; tbl[2].data = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].idx = 4'd1; tbl[2].val = 8'h80;
        tbl[3].d = 0; tbl[3].data = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3].idx = 4'd0; tbl[3].val = 8'h7F;
        tbl[4].d = 2; tbl[4].data = '{8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4].idx = 4'd0; tbl[4].val = 8'hFC;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 10; i++) mem[d][i] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_busy_done%0d", d), {busy_v[d], done_v[d]}, 0);
            check($sformatf("reset_addr%0d", d), raddr[d], 0);
            check($sformatf("reset_result%0d", d), {cidx[d], mval[d]}, 0);
            check($sformatf("reset_state%0d", d), st[d], 0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < depth(tbl[v].d); i++) mem[tbl[v].d][i] = tbl[v].data[i];
            run_scan(tbl[v].d, -1, lat, idx, val, ok);
            check($sformatf("vec%0d_idx", v), idx, tbl[v].idx);
            check($sformatf("vec%0d_val", v), val, tbl[v].val);
            check($sformatf("vec%0d_latency", v), lat, depth(tbl[v].d) + 2);
            check($sformatf("vec%0d_addr_busy_hold", v), ok, 1);
        end

        // Start re-pulsed mid-scan is ignored; previous result (0x7F) held until done
        for (int i = 0; i < 10; i++) mem[0][i] = tbl[0].data[i];
        run_scan(0, 5, lat, idx, val, ok);
        check("ignored_start_idx", idx, 4);
        check("ignored_start_val", val, 8'h2A);
        check("ignored_start_latency", lat, 12);
        check("ignored_start_hold", ok, 1);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_v[0]) cnt++;
        end
        check("ignored_start_extra_done", cnt, 0);

        // Asynchronous reset mid-scan
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_busy_done", {busy_v[0], done_v[0]}, 0);
        check("midreset_addr", raddr[0], 0);
        check("midreset_result", {cidx[0], mval[0]}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_v[0] || busy_v[0]) cnt++;
        end
        check("midreset_no_resume", cnt, 0);
        run_scan(0, -1, lat, idx, val, ok);
        check("after_reset_idx", idx, 4);
        check("after_reset_val", val, 8'h2A);
        check("after_reset_latency", lat, 12);

        // NUM_CLASSES=1 back-to-back with start held high
        mem[2][0] = 8'hFC;
        @(negedge clk);
        start_v[2] = 1'b1;
        @(posedge clk);
        lat = 0; t1 = -1; t2 = -1; ok = 1'b1;
        while (lat < 20 && t2 < 0) begin
            @(posedge clk);
            lat++;
            #1;
            if (done_v[2]) begin
                if (cidx[2] != 4'd0 || mval[2] != 8'hFC) ok = 1'b0;
                if (t1 < 0) t1 = lat;
                else t2 = lat;
            end
        end
        @(negedge clk);
        start_v[2] = 1'b0;
        check("n1_first_done", t1, 3);
        check("n1_back_to_back_gap", t2 - t1, 4);
        check("n1_results", ok, 1);
        repeat (8) @(posedge clk);

        // Randomized scans against the reference model
        for (int r = 0; r < 30; r++) begin
            int d;
            d = $urandom_range(0, 2);
            for (int i = 0; i < depth(d); i++) begin
                case ($urandom_range(0, 5))
                    0: mem[d][i] = 8'h7F;
                    1: mem[d][i] = 8'h80;
                    2: mem[d][i] = 8'hFF;
                    default: mem[d][i] = 8'($urandom_range(0, 255));
                endcase
            end
            ref_model(d, e_idx, e_val);
            run_scan(d, -1, lat, idx, val, ok);
            check($sformatf("rand%0d_d%0d_idx", r, d), idx, e_idx);
            check($sformatf("rand%0d_d%0d_val", r, d), val, e_val);
            check($sformatf("rand%0d_d%0d_latency", r, d), lat, depth(d) + 2);
            check($sformatf("rand%0d_d%0d_side", r, d), ok, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
